// File: rtl/mult32x32_arbiter_if.sv
// Requester and multiplier-side bundle for mult32x32_arbiter; slave = arbiter, master = clients plus multiplier.
// Requesters hold req with stable operands until gnt; gnt/done/mul_start are single-cycle pulses.
interface mult32x32_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [63:0]          result;
    logic                 mul_start;
    logic [31:0]          mul_a;
    logic [31:0]          mul_b;
    logic                 mul_busy;
    logic [63:0]          mul_product;

    modport slave (
        input  req, req_a, req_b, mul_busy, mul_product,
        output gnt, done, err, result, mul_start, mul_a, mul_b
    );

    modport master (
        output req, req_a, req_b, mul_busy, mul_product,
        input  gnt, done, err, result, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mult32x32_arbiter.sv
// Round-robin sequencer sharing one mult32x32_fast among NREQ requesters; gnt->done = 3+Nbusy cycles.
// Requesters hold req until gnt (no other backpressure); MARB_TIMEOUT_EN adds a wait timeout reported via err.
module mult32x32_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               reset,
    mult32x32_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 2) ? 2 : 1;

    if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("mult32x32_arbiter: NREQ must be 2..4 and TIMEOUT_CYC >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   pick, idx;
    logic            any_req;
    logic [31:0]     mul_a_q, mul_a_d;
    logic [31:0]     mul_b_q, mul_b_d;
    logic [63:0]     result_q, result_d;
    logic [NREQ-1:0] gnt, done;
    logic            mul_start;

`ifdef MARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            tmo;
    assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));
`endif

    // Scan from rr_ptr downward in offset so the nearest requester at/after rr_ptr wins.
    always_comb begin
        pick    = rr_ptr_q;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (bus.req[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        result_d  = result_q;
        gnt       = '0;
        done      = '0;
        mul_start = 1'b0;
`ifdef MARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req && reset) begin
                    gnt[pick] = 1'b1;
                    sel_d     = pick;
                    rr_ptr_d  = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    mul_a_d   = bus.req_a[32*pick +: 32];
                    mul_b_d   = bus.req_b[32*pick +: 32];
                    state_d   = S_START;
`ifdef MARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            S_START: begin
                mul_start = 1'b1;
                state_d   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
`ifdef MARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (tmo) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else if (bus.mul_busy) begin
                    state_d = S_WAIT_DONE;
                end
`else
                if (bus.mul_busy) state_d = S_WAIT_DONE;
`endif
            end
            S_WAIT_DONE: begin
`ifdef MARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (tmo) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else if (!bus.mul_busy) begin
                    result_d = bus.mul_product;
                    state_d  = S_RESP;
                end
`else
                if (!bus.mul_busy) begin
                    result_d = bus.mul_product;
                    state_d  = S_RESP;
                end
`endif
            end
            S_RESP: begin
                done[sel_q] = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
`ifdef MARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            result_q <= result_d;
`ifdef MARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.gnt       = gnt;
    assign bus.done      = done;
    assign bus.mul_start = mul_start;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.result    = result_q;
`ifdef MARB_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Directed bench for mult32x32_arbiter with a behavioural multiplier (busy 2 cycles when both operands fit 16 bits, else 5).
module tb_mult32x32_arbiter;
    localparam int NREQ = 2;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult32x32_arbiter_if #(.NREQ(NREQ)) bus ();
    mult32x32_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: product is garbage while busy, valid once busy falls.
    int unsigned m_cnt;
    logic [63:0] m_prod;
    bit          hang = 1'b0;
    always @(posedge clk) begin
        if (!reset) begin
            bus.mul_busy    <= 1'b0;
            bus.mul_product <= '0;
            m_cnt           <= 0;
        end else if (bus.mul_start) begin
            m_prod          <= 64'(bus.mul_a) * 64'(bus.mul_b);
            bus.mul_busy    <= 1'b1;
            bus.mul_product <= 64'hDEAD_BEEF_DEAD_BEEF;
            m_cnt           <= (bus.mul_a[31:16] == 0 && bus.mul_b[31:16] == 0) ? 1 : 4;
        end else if (bus.mul_busy) begin
            if (m_cnt == 0) begin
                if (!hang) begin
                    bus.mul_busy    <= 1'b0;
                    bus.mul_product <= m_prod;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int nbusy, input string nm);
        int tg, td;
        logic [NREQ-1:0] eg;
        eg = '0;
        eg[idx] = 1'b1;
        bus.req_a[32*idx +: 32] = a;
        bus.req_b[32*idx +: 32] = b;
        bus.req[idx] = 1'b1;
        #1;
        tg = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.gnt !== '0) begin tg = cyc; break; end
            @(posedge clk); #1;
        end
        n_chk++;
        if (tg < 0 || bus.gnt !== eg) begin
            n_fail++;
            $display("FAIL %s_gnt: got %b, expected %b", nm, bus.gnt, eg);
        end
        @(posedge clk); #1;
        bus.req[idx] = 1'b0;
        n_chk++;
        if (bus.mul_start !== 1'b1 || bus.gnt !== '0) begin
            n_fail++;
            $display("FAIL %s_start: got start=%b gnt=%b, expected start=1 gnt=0", nm, bus.mul_start, bus.gnt);
        end
        n_chk++;
        if (bus.mul_a !== a || bus.mul_b !== b) begin
            n_fail++;
            $display("FAIL %s_operands: got %h/%h, expected %h/%h", nm, bus.mul_a, bus.mul_b, a, b);
        end
        @(posedge clk); #1;
        n_chk++;
        if (bus.mul_start !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start_len: got start=%b, expected 0", nm, bus.mul_start);
        end
        td = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.done !== '0) begin td = cyc; break; end
            @(posedge clk); #1;
        end
        n_chk++;
        if (td < 0 || td - tg != 3 + nbusy) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d, expected %0d", nm, td - tg, 3 + nbusy);
        end
        n_chk++;
        if (bus.done !== eg) begin
            n_fail++;
            $display("FAIL %s_done: got %b, expected %b", nm, bus.done, eg);
        end
        n_chk++;
        if (bus.result !== exp || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_result: got %0d err=%b, expected %0d err=0", nm, bus.result, bus.err, exp);
        end
        @(posedge clk); #1;
        n_chk++;
        if (bus.done !== '0 || bus.result !== exp) begin
            n_fail++;
            $display("FAIL %s_hold: got done=%b result=%0d, expected done=0 result=%0d", nm, bus.done, bus.result, exp);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.req   = 2'b01;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (4) begin
            @(posedge clk); #1;
            n_chk++;
            if (bus.gnt !== '0 || bus.done !== '0 || bus.mul_start !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got gnt=%b done=%b start=%b, expected all 0", bus.gnt, bus.done, bus.mul_start);
            end
        end
        bus.req = '0;
        reset   = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (bus.result !== 64'd0 || bus.mul_a !== 32'd0 || bus.mul_b !== 32'd0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got result=%h a=%h b=%h err=%b, expected 0", bus.result, bus.mul_a, bus.mul_b, bus.err);
        end
        n_chk++;
        if (dut.state_q !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, expected 0", dut.state_q);
        end
    endtask

    task automatic test_single();
        do_op(0, 32'h13404874, 32'h11E2F516, 64'd96921940715191800, 5, "single");
    endtask

    task automatic test_fast();
        do_op(1, 32'h00004874, 32'h0000F516, 64'd1163738616, 2, "fast");
    endtask

    task automatic test_round_robin();
        int tg, td, prev, g;
        logic [NREQ-1:0] eg;
        logic [63:0] er;
        bus.req_a = {32'd7, 32'd3};
        bus.req_b = {32'd11, 32'd5};
        bus.req   = 2'b11;
        #1;
        prev = -1;
        for (int op = 0; op < 6; op++) begin
            g = op % 2;
            eg = '0;
            eg[g] = 1'b1;
            er = (g == 1) ? 64'd77 : 64'd15;
            tg = -1;
            for (int i = 0; i < 20; i++) begin
                if (bus.gnt !== '0) begin tg = cyc; break; end
                @(posedge clk); #1;
            end
            n_chk++;
            if (tg < 0 || bus.gnt !== eg) begin
                n_fail++;
                $display("FAIL rr_gnt op%0d: got %b, expected %b", op, bus.gnt, eg);
            end
            if (op > 0) begin
                n_chk++;
                if (tg - prev != 6) begin
                    n_fail++;
                    $display("FAIL rr_spacing op%0d: got %0d, expected 6", op, tg - prev);
                end
            end
            prev = tg;
            @(posedge clk); #1;
            bus.req[g] = 1'b0;
            td = -1;
            for (int i = 0; i < 50; i++) begin
                if (bus.done !== '0) begin td = cyc; break; end
                @(posedge clk); #1;
            end
            n_chk++;
            if (td < 0 || bus.done !== eg || bus.result !== er) begin
                n_fail++;
                $display("FAIL rr_done op%0d: got done=%b result=%0d, expected done=%b result=%0d", op, bus.done, bus.result, eg, er);
            end
            // Requester re-raises in its own done cycle.
            if (op < 4) bus.req[g] = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int tg;
        bit seen;
        bus.req_a[31:0] = 32'h13404874;
        bus.req_b[31:0] = 32'h11E2F516;
        bus.req[0] = 1'b1;
        #1;
        tg = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.gnt !== '0) begin tg = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.req[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_chk++;
        if (tg < 0 || dut.state_q !== 3'd3 || bus.mul_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup: got state=%0d busy=%b, expected state=3 busy=1", dut.state_q, bus.mul_busy);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (bus.done !== '0 || bus.mul_start !== 1'b0 || bus.result !== 64'd0 || bus.mul_a !== 32'd0 || bus.mul_b !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: got done=%b start=%b result=%h a=%h, expected all 0", bus.done, bus.mul_start, bus.result, bus.mul_a);
        end
        reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done !== '0) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin
            n_fail++;
            $display("FAIL midrst_nodone: got done pulse, expected none");
        end
        do_op(1, 32'h00004874, 32'h0000F516, 64'd1163738616, 2, "after_rst");
    endtask

`ifdef MARB_TIMEOUT_EN
    task automatic test_timeout();
        int tg, td;
        hang = 1'b1;
        bus.req_a[31:0] = 32'd3;
        bus.req_b[31:0] = 32'd5;
        bus.req[0] = 1'b1;
        #1;
        tg = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.gnt !== '0) begin tg = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.req[0] = 1'b0;
        td = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.done !== '0) begin td = cyc; break; end
            @(posedge clk); #1;
        end
        n_chk++;
        if (tg < 0 || td < 0 || td - tg != 2 + TMO) begin
            n_fail++;
            $display("FAIL tmo_latency: got %0d, expected %0d", td - tg, 2 + TMO);
        end
        n_chk++;
        if (bus.done !== 2'b01 || bus.err !== 1'b1 || bus.result !== 64'd0) begin
            n_fail++;
            $display("FAIL tmo_resp: got done=%b err=%b result=%h, expected done=01 err=1 result=0", bus.done, bus.err, bus.result);
        end
        hang = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        reset     = 1'b0;
        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        test_reset();
        test_single();
        test_fast();
        test_round_robin();
        test_reset_mid();
`ifdef MARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
